// File: rtl/seq_wide_adder_pkg.sv
// Shared types and helpers for the multi-cycle wide adder/subtractor.
package seq_wide_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/rca_nbit.sv
// Plain n-bit ripple-carry adder slice, purely combinational.
module rca_nbit #(
  parameter int n = 4
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         ci,
  output logic [n-1:0] s,
  output logic         co
);

  logic [n:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < n; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[n];
  end

endmodule

// File: rtl/seq_wide_adder.sv
// Wide add/subtract built from one shared N-bit slice stepped over WORDS cycles.
// state | meaning
// IDLE  | waiting for a request, start_ready high
// RUN   | one slice per cycle, carry held in a register
// DONE  | result held until the consumer takes it
module seq_wide_adder
  import seq_wide_adder_pkg::*;
#(
  parameter int N     = 4,
  parameter int WORDS = 4,
  parameter int W     = N * WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         overflow,
  output logic         done_valid,
  input  logic         done_ready
);

  localparam int CW = cnt_width(WORDS);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic          carry;
  logic          sub_q;
  logic          a_msb;
  logic          b_msb;
  logic [N-1:0]  slice_s;
  logic          slice_co;

  assign start_ready = (state == IDLE);

  rca_nbit #(.n(N)) u_slice (
    .a  (a_sh[N-1:0]),
    .b  (b_sh[N-1:0]),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      a_sh       <= '0;
      b_sh       <= '0;
      carry      <= 1'b0;
      sub_q      <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      sum        <= '0;
      c_out      <= 1'b0;
      overflow   <= 1'b0;
      done_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            // Subtraction is A + ~B + ~borrow, so invert B and the carry here.
            a_sh  <= a;
            b_sh  <= b ^ {W{sub}};
            carry <= c_in ^ sub;
            sub_q <= sub;
            a_msb <= a[W-1];
            b_msb <= b[W-1];
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum[int'(cnt)*N +: N] <= slice_s;
          carry <= slice_co;
          a_sh  <= a_sh >> N;
          b_sh  <= b_sh >> N;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state      <= DONE;
            done_valid <= 1'b1;
            c_out      <= slice_co;
            overflow   <= (a_msb == (b_msb ^ sub_q)) && (slice_s[N-1] != a_msb);
          end
        end
        DONE: begin
          if (done_ready) begin
            done_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_wide_adder.sv
// Directed bench for seq_wide_adder (N=4, WORDS=4) with an arithmetic reference model.
module tb_seq_wide_adder;

  localparam int N = 4;
  localparam int WORDS = 4;
  localparam int W = N * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;
  logic         done_valid;
  logic         done_ready = 1'b1;

  int n_pass = 0;
  int n_total = 0;

  seq_wide_adder #(.N(N), .WORDS(WORDS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .c_in        (c_in),
    .sub         (sub),
    .sum         (sum),
    .c_out       (c_out),
    .overflow    (overflow),
    .done_valid  (done_valid),
    .done_ready  (done_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference arithmetic on whole integers, independent of slicing.
  function automatic void calc(input logic [15:0] x, input logic [15:0] y, input logic ci,
                               input logic s, output logic [15:0] r, output logic co,
                               output logic ov);
    int ux, uy, sx, sy, ur, sr;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!s) begin
      ur = ux + uy + int'(ci);
      sr = sx + sy + int'(ci);
      co = (ur > 65535);
    end else begin
      ur = ux - uy - int'(ci);
      sr = sx - sy - int'(ci);
      co = (ur >= 0);
    end
    r  = ur[15:0];
    ov = (sr > 32767) || (sr < -32768);
  endfunction

  // Protocol-level model: accept when idle, result visible WORDS edges later.
  bit          m_live = 0;
  bit          m_dv = 0;
  bit          m_fresh = 0;
  int          m_left = 0;
  logic [15:0] p_sum, e_sum;
  logic        p_co, p_ov, e_co, e_ov;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_live  = 1;
      m_dv    = 0;
      m_left  = 0;
      m_fresh = 1;
    end else if (m_live) begin
      if (m_dv) begin
        if (done_ready) m_dv = 0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_dv  = 1;
          e_sum = p_sum;
          e_co  = p_co;
          e_ov  = p_ov;
        end
      end else if (start_valid) begin
        calc(a, b, c_in, sub, p_sum, p_co, p_ov);
        m_left  = WORDS;
        m_fresh = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("start_ready", 32'(start_ready), 32'(!m_dv && m_left == 0));
      chk("done_valid", 32'(done_valid), 32'(m_dv));
      if (m_dv) begin
        chk("sum", 32'(sum), 32'(e_sum));
        chk("c_out", 32'(c_out), 32'(e_co));
        chk("overflow", 32'(overflow), 32'(e_ov));
      end else if (m_fresh) begin
        chk("reset sum", 32'(sum), 32'h0);
        chk("reset c_out", 32'(c_out), 32'h0);
        chk("reset overflow", 32'(overflow), 32'h0);
      end
    end
  end

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, 32'(n), 32'(WORDS));
  endtask

  task automatic do_op(input string nm, input logic [15:0] x, input logic [15:0] y,
                       input logic ci, input logic s, input logic [15:0] er,
                       input logic eco, input logic eov);
    logic [15:0] r;
    logic        co, ov;
    calc(x, y, ci, s, r, co, ov);
    chk({nm, " model sum"}, 32'(r), 32'(er));
    chk({nm, " model c_out"}, 32'(co), 32'(eco));
    chk({nm, " model ovf"}, 32'(ov), 32'(eov));
    @(negedge clk);
    a = x; b = y; c_in = ci; sub = s;
    start_valid = 1'b1;
    done_ready  = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
    wait_done(nm);
    chk({nm, " sum"}, 32'(sum), 32'(er));
    chk({nm, " c_out"}, 32'(c_out), 32'(eco));
    chk({nm, " overflow"}, 32'(overflow), 32'(eov));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset start_ready", 32'(start_ready), 32'h1);
    chk("reset done_valid", 32'(done_valid), 32'h0);
    rst_n = 1'b1;

    do_op("add",      16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    do_op("ripple",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("subtract", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("ovf add",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("ovf sub",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    do_op("add cin",  16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
    do_op("sub bin",  16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);

    // Backpressure: result held while a new request waits at the door.
    @(negedge clk);
    a = 16'h0101; b = 16'h0202; c_in = 1'b0; sub = 1'b0;
    start_valid = 1'b1;
    done_ready  = 1'b0;
    @(negedge clk);
    a = 16'h1111; b = 16'h2222;
    wait_done("bp first");
    chk("bp first sum", 32'(sum), 32'h0303);
    repeat (5) begin
      @(negedge clk);
      chk("bp start_ready", 32'(start_ready), 32'h0);
      chk("bp sum hold", 32'(sum), 32'h0303);
      chk("bp done_valid hold", 32'(done_valid), 32'h1);
    end
    done_ready = 1'b1;
    @(negedge clk);
    chk("bp release done_valid", 32'(done_valid), 32'h0);
    chk("bp release start_ready", 32'(start_ready), 32'h1);
    @(negedge clk);
    start_valid = 1'b0;
    chk("bp second accepted", 32'(start_ready), 32'h0);
    wait_done("bp second");
    chk("bp second sum", 32'(sum), 32'h3333);
    @(negedge clk);

    // Reset while the slice counter sits at 2.
    @(negedge clk);
    a = 16'hABCD; b = 16'h1357; c_in = 1'b0; sub = 1'b0;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort done_valid", 32'(done_valid), 32'h0);
    chk("abort sum", 32'(sum), 32'h0);
    chk("abort start_ready", 32'(start_ready), 32'h1);
    repeat (6) begin
      @(negedge clk);
      chk("abort no pulse", 32'(done_valid), 32'h0);
    end
    do_op("after reset", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
